// File: rtl/score_bcd_if.sv
// Custom-instruction handshake between the Nios II core and the score_bcd converter.
// The master drives the operands and strobes; the slave returns result and done.
interface score_bcd_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    modport master (output clk_en, start, dataa, datab, input result, done);
    modport slave  (input clk_en, start, dataa, datab, output result, done);
endinterface

// File: rtl/score_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per enabled clock.
// The result word carries either the low eight digits or the top digits plus a significant-digit count.
module score_bcd #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input logic        clk,
    input logic        reset_n,
    score_bcd_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int PAD_W = (DIGITS > 10) ? BCD_W : 40;

    typedef enum logic [1:0] {IDLE, SHIFT, PRONTO} state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               sel;
    logic [31:0]        result_q;
    logic               done_q;
    logic [3:0]         sig_digits;
    logic [PAD_W-1:0]   bcd_pad;
    logic [31:0]        word_lo;
    logic [31:0]        word_hi;
    logic               unused_bits;

    assign unused_bits = ^{bus.datab[31:1], bus.dataa};

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Highest non-zero digit index plus one; an all-zero value still shows one digit.
    always_comb begin
        sig_digits = 4'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                sig_digits = 4'(i + 1);
        end
    end

    assign bcd_pad = PAD_W'(bcd);
    assign word_lo = bcd_pad[31:0];
    assign word_hi = {12'd0, sig_digits, 8'd0, bcd_pad[39:32]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            sel      <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (bus.clk_en) begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shreg <= bus.dataa[WIDTH-1:0];
                        bcd   <= '0;
                        cnt   <= '0;
                        sel   <= bus.datab[0];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
                    cnt          <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= PRONTO;
                end
                PRONTO: begin
                    result_q <= sel ? word_hi : word_lo;
                    done_q   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_score_bcd.sv
// Directed bench for score_bcd: latency, result words, done pulse, clk_en stalls and reset abort.
module tb_score_bcd;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   lat;
    int   done_seen;

    score_bcd_if bus();

    score_bcd #(.WIDTH(32), .DIGITS(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Called #1 after a rising edge; the start pulse is sampled on the next edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.dataa  = a;
        bus.datab  = b;
        bus.start  = 1'b1;
        bus.clk_en = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the start edge until done; lat stays 0 if the budget expires.
    task automatic wait_done(input int gap_at, input int gap_len, input int inject_at,
                             input logic [31:0] inj_a, output int lat_o);
        lat_o = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            bus.start  = (n == inject_at);
            if (n == inject_at) begin
                bus.dataa = inj_a;
                bus.datab = 32'd0;
            end
            bus.clk_en = !(n >= gap_at && n < gap_at + gap_len);
            if (bus.done) begin
                lat_o = n;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r);
        int l;
        start_op(a, b);
        wait_done(0, 0, 0, 32'd0, l);
        check({tag, "_latency"}, 32'(l), 32'd33);
        check({tag, "_result"}, bus.result, exp_r);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.dataa  = '0;
        bus.datab  = '0;
        reset_n    = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_result", bus.result, 32'h0000_0000);
        check("reset_done", 32'(bus.done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        run("zero_lo", 32'd0, 32'd0, 32'h0000_0000);
        run("zero_hi", 32'd0, 32'd1, 32'h0001_0000);
        run("12345678_lo", 32'd12345678, 32'd0, 32'h1234_5678);
        run("12345678_hi", 32'd12345678, 32'd1, 32'h0008_0000);
        run("max_lo", 32'hFFFF_FFFF, 32'd0, 32'h9496_7295);
        run("max_hi", 32'hFFFF_FFFF, 32'd1, 32'h000A_0042);

        // A second start while busy must neither disturb nor queue behind the first.
        start_op(32'd1000000000, 32'd1);
        wait_done(0, 0, 10, 32'd5, lat);
        check("billion_latency", 32'(lat), 32'd33);
        check("billion_result", bus.result, 32'h000A_0010);
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check("ignored_start_no_done", 32'(done_seen), 32'd0);
        check("ignored_start_result", bus.result, 32'h000A_0010);

        // Seven disabled edges mid-SHIFT stretch latency; done holds while clk_en is low.
        start_op(32'd999, 32'd0);
        wait_done(10, 7, 0, 32'd0, lat);
        check("stall_latency", 32'(lat), 32'd40);
        check("stall_result", bus.result, 32'h0000_0999);
        bus.clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stall_done_hold", 32'(bus.done), 32'd1);
        bus.clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("stall_done_clear", 32'(bus.done), 32'd0);
        check("stall_result_hold", bus.result, 32'h0000_0999);

        start_op(32'd123456789, 32'd0);
        repeat (15) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_result", bus.result, 32'h0000_0000);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_done_held", 32'(bus.done), 32'd0);
        reset_n = 1'b1;
        run("after_reset_42", 32'd42, 32'd0, 32'h0000_0042);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_bcd.md
Name: score_bcd

Overview:
- Multi-cycle Nios II custom instruction that converts the 32-bit binary score or coordinate value into packed BCD for the seven-segment score display.
- Sits directly downstream of the modulo/remainder custom instruction. Game software passes the remainder or score result here; the returned BCD word drives the display PIO.
- Uses the sequential shift-and-add-3 (double-dabble) algorithm, one input bit per clock.
- Uses the same start/done/clk_en handshake as the other arithmetic custom instructions.

Parameters:
- WIDTH, 32, binary input width in bits (valid range 8..32).
- DIGITS, 10, number of BCD digits held internally. Must be at least ceil(WIDTH*log10(2)); 10 for 32 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clk_en  input  1  clock enable; when low, all registers hold.
- start  input  1  begin conversion; sampled only in IDLE with clk_en high.
- dataa  input  32  binary value; low WIDTH bits are used, upper bits ignored.
- datab  input  32  bit 0 selects result word: 0 = low word, 1 = high word. Other bits ignored.
- result  output  32  registered converted word.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_n low, asynchronous): result=0, done=0, state=IDLE, shift register=0, BCD register=0, bit counter=0, select=0.
- clk_en low: every register holds, including done and result. Latency stretches by the number of disabled cycles.
- States:
  - IDLE: done<=0. On start, load the shift register with dataa[WIDTH-1:0], clear the BCD register (4*DIGITS bits), counter<=0, latch select<=datab[0], go to SHIFT. start with clk_en low is ignored.
  - SHIFT: in one clock, each BCD nibble >=5 gets +3, then {bcd, shreg} shifts left by 1 and counter increments. When counter==WIDTH-1 on this edge, go to PRONTO. Exactly WIDTH shift cycles are performed.
  - PRONTO: result<=selected word, done<=1, state<=IDLE.
- Result words:
  - select=0: result = BCD digits 7..0, digit 7 in [31:28], digit 0 in [3:0].
  - select=1: result[7:0] = digits 9..8; result[19:16] = significant digit count (index of highest non-zero digit + 1, 1..10; value 0 gives 1); all other bits 0.
- Timing: start sampled at edge k. Shifts occur at edges k+1..k+WIDTH. PRONTO executes at edge k+WIDTH+1, so done is high for the single cycle after that edge (33 cycles after start for WIDTH=32). done clears at edge k+WIDTH+2.
- result holds its value until the next PRONTO or reset.
- start asserted in SHIFT or PRONTO is ignored. There is no queuing, and the operands in flight are unaffected.
- Reset mid-conversion aborts immediately to the reset values; no done pulse is issued.
- Arithmetic: add-3 correction is per nibble and 4 bits wide, and never overflows because each nibble is <=9 after a shift. No overflow is possible for WIDTH<=32 with DIGITS=10.

Test Plan:
- dataa=0, datab=0 -> done after 33 cycles, result=0x00000000. Repeat with datab=1 -> result=0x00010000 (count 1).
- dataa=12345678, datab=0 -> result=0x12345678. Repeat with datab=1 -> result=0x00080000.
- dataa=0xFFFFFFFF: datab=0 -> 0x94967295; datab=1 -> 0x000A0042.
- dataa=1000000000, datab=1 -> result=0x000A0010. Issue start again after 10 cycles with dataa=5 -> ignored, result unchanged.
- dataa=999, clk_en low for 7 cycles mid-SHIFT -> done after 40 cycles, result=0x00000999. Check that done stays high for exactly 1 enabled cycle.
- Pull reset_n low at cycle 15 of a conversion -> result=0 and done=0 asynchronously. Then release reset_n, start with dataa=42 -> result=0x00000042.
